// File: rtl/tb_exit_pkg.sv
// tb_exit_pkg: shared status/state encodings and the status-to-verdict helpers
// for the end-of-simulation monitor.
package tb_exit_pkg;

    localparam int EXIT_VALUE_W = 32;

    typedef enum logic [2:0] {
        ST_NONE     = 3'd0,
        ST_PASS     = 3'd1,
        ST_FAIL     = 3'd2,
        ST_EXIT_OK  = 3'd3,
        ST_EXIT_ERR = 3'd4,
        ST_TIMEOUT  = 3'd5,
        ST_WDOG     = 3'd6
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic is_pass(status_e s);
        return (s == ST_PASS) || (s == ST_EXIT_OK);
    endfunction

    function automatic logic is_fail(status_e s);
        return (s != ST_NONE) && !is_pass(s);
    endfunction

endpackage

// File: rtl/tb_exit_arbiter.sv
// tb_exit_arbiter: combinational priority encoder picking one end-of-sim event
// from the exit channels plus the timeout and watchdog conditions.
module tb_exit_arbiter
    import tb_exit_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int CH_W = 1
) (
    input  logic [NCH-1:0]              pass_i,
    input  logic [NCH-1:0]              fail_i,
    input  logic [NCH-1:0]              exit_valid_i,
    input  logic [EXIT_VALUE_W*NCH-1:0] exit_value_i,
    input  logic                        timeout_i,
    input  logic                        wdog_i,
    output logic                        valid_o,
    output status_e                     status_o,
    output logic [CH_W-1:0]             ch_o,
    output logic [EXIT_VALUE_W-1:0]     value_o
);

    logic                    fail_hit, err_hit, pass_hit, ok_hit;
    logic [CH_W-1:0]         fail_ch, err_ch, pass_ch, ok_ch;
    logic [EXIT_VALUE_W-1:0] err_val;

    always_comb begin
        fail_hit = 1'b0;
        err_hit  = 1'b0;
        pass_hit = 1'b0;
        ok_hit   = 1'b0;
        fail_ch  = '0;
        err_ch   = '0;
        pass_ch  = '0;
        ok_ch    = '0;
        err_val  = '0;
        // Walk from the top channel down so the lowest index is the last writer.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (fail_i[k]) begin
                fail_hit = 1'b1;
                fail_ch  = CH_W'(k);
            end
            if (exit_valid_i[k] && exit_value_i[EXIT_VALUE_W*k +: EXIT_VALUE_W] != '0) begin
                err_hit = 1'b1;
                err_ch  = CH_W'(k);
                err_val = exit_value_i[EXIT_VALUE_W*k +: EXIT_VALUE_W];
            end
            if (pass_i[k]) begin
                pass_hit = 1'b1;
                pass_ch  = CH_W'(k);
            end
            if (exit_valid_i[k] && exit_value_i[EXIT_VALUE_W*k +: EXIT_VALUE_W] == '0) begin
                ok_hit = 1'b1;
                ok_ch  = CH_W'(k);
            end
        end
        valid_o  = fail_hit | err_hit | pass_hit | ok_hit | timeout_i | wdog_i;
        status_o = fail_hit  ? ST_FAIL     :
                   err_hit   ? ST_EXIT_ERR :
                   pass_hit  ? ST_PASS     :
                   ok_hit    ? ST_EXIT_OK  :
                   timeout_i ? ST_TIMEOUT  :
                   wdog_i    ? ST_WDOG     : ST_NONE;
        ch_o     = fail_hit ? fail_ch :
                   err_hit  ? err_ch  :
                   pass_hit ? pass_ch :
                   ok_hit   ? ok_ch   : '0;
        value_o  = (!fail_hit && err_hit) ? err_val : '0;
    end

endmodule

// File: rtl/tb_exit_monitor.sv
// tb_exit_monitor: end-of-simulation monitor with cycle limit, idle watchdog,
// one-shot event capture and a drain period before the sticky done flag.
module tb_exit_monitor
    import tb_exit_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int CNT_W        = 32,
    parameter int WDOG_CYCLES  = 100000,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   enable_i,
    input  logic [CNT_W-1:0]                       max_cycles_i,
    input  logic                                   retire_i,
    input  logic [NCH-1:0]                         pass_i,
    input  logic [NCH-1:0]                         fail_i,
    input  logic [NCH-1:0]                         exit_valid_i,
    input  logic [32*NCH-1:0]                      exit_value_i,
    output logic                                   done_o,
    output logic [2:0]                             status_o,
    output logic [31:0]                            exit_value_o,
    output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] src_ch_o,
    output logic [CNT_W-1:0]                       cycle_cnt_o,
    output logic                                   tests_passed_o,
    output logic                                   tests_failed_o
);

    localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
    localparam int DW   = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int IW   = WDOG_CYCLES > 0 ? $clog2(WDOG_CYCLES + 1) : 1;

    state_e                  state_q, state_d;
    status_e                 status_q, status_d, ev_status;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]           idle_q, idle_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [EXIT_VALUE_W-1:0] value_q, value_d, ev_value;
    logic [CH_W-1:0]         src_q, src_d, ev_ch;
    logic                    done_q, done_d, passed_q, passed_d, failed_q, failed_d;
    logic                    ev_valid, timeout, wdog;

    assign timeout = (max_cycles_i != '0) && (cnt_q >= max_cycles_i);
    assign wdog    = (WDOG_CYCLES != 0) && (idle_q == IW'(WDOG_CYCLES));

    tb_exit_arbiter #(.NCH(NCH), .CH_W(CH_W)) u_arb (
        .pass_i       (pass_i),
        .fail_i       (fail_i),
        .exit_valid_i (exit_valid_i),
        .exit_value_i (exit_value_i),
        .timeout_i    (timeout),
        .wdog_i       (wdog),
        .valid_o      (ev_valid),
        .status_o     (ev_status),
        .ch_o         (ev_ch),
        .value_o      (ev_value)
    );

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        value_d  = value_q;
        src_d    = src_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = enable_i ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (ev_valid) begin
                    state_d  = DRAIN_CYCLES == 0 ? S_DONE : S_DRAIN;
                    drain_d  = '0;
                    status_d = ev_status;
                    src_d    = ev_ch;
                    value_d  = ev_value;
                end else if (enable_i && cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DW'(1);
                state_d = (drain_q + DW'(1) == DW'(DRAIN_CYCLES)) ? S_DONE : S_DRAIN;
            end
            default: ;
        endcase
        idle_d   = (state_q != S_RUN || retire_i) ? '0 :
                   (enable_i && idle_q != IW'(WDOG_CYCLES)) ? idle_q + IW'(1) : idle_q;
        done_d   = state_d == S_DONE;
        passed_d = done_d && is_pass(status_d);
        failed_d = done_d && is_fail(status_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            status_q <= ST_NONE;
            cnt_q    <= '0;
            idle_q   <= '0;
            drain_q  <= '0;
            value_q  <= '0;
            src_q    <= '0;
            done_q   <= 1'b0;
            passed_q <= 1'b0;
            failed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            drain_q  <= drain_d;
            value_q  <= value_d;
            src_q    <= src_d;
            done_q   <= done_d;
            passed_q <= passed_d;
            failed_q <= failed_d;
        end
    end

    assign done_o         = done_q;
    assign status_o       = status_q;
    assign exit_value_o   = value_q;
    assign src_ch_o       = src_q;
    assign cycle_cnt_o    = cnt_q;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;

endmodule

// File: tb/tb_tb_exit_monitor.sv
// tb_tb_exit_monitor: directed bench for tb_exit_monitor; one instance with the
// watchdog off and a 16-cycle drain, one with a 20-cycle watchdog and no drain.
module tb_tb_exit_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] max_cycles = '0;
    logic        retire = 1'b0;
    logic [1:0]  pass = '0, fail = '0, exit_valid = '0;
    logic [63:0] exit_value = '0;

    logic        done, passed, failed, src;
    logic [2:0]  status;
    logic [31:0] value, cnt;
    logic        w_done, w_passed, w_failed, w_src;
    logic [2:0]  w_status;
    logic [31:0] w_value, w_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tb_exit_monitor #(.NCH(2), .CNT_W(32), .WDOG_CYCLES(0), .DRAIN_CYCLES(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .max_cycles_i(max_cycles),
        .retire_i(retire), .pass_i(pass), .fail_i(fail), .exit_valid_i(exit_valid),
        .exit_value_i(exit_value), .done_o(done), .status_o(status), .exit_value_o(value),
        .src_ch_o(src), .cycle_cnt_o(cnt), .tests_passed_o(passed), .tests_failed_o(failed)
    );

    tb_exit_monitor #(.NCH(2), .CNT_W(32), .WDOG_CYCLES(20), .DRAIN_CYCLES(0)) u_wd (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .max_cycles_i(max_cycles),
        .retire_i(retire), .pass_i(pass), .fail_i(fail), .exit_valid_i(exit_valid),
        .exit_value_i(exit_value), .done_o(w_done), .status_o(w_status), .exit_value_o(w_value),
        .src_ch_o(w_src), .cycle_cnt_o(w_cnt), .tests_passed_o(w_passed), .tests_failed_o(w_failed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        max_cycles = '0;
        retire = 1'b0;
        pass = '0;
        fail = '0;
        exit_valid = '0;
        exit_value = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One edge to leave IDLE; the counter reads 0 afterwards.
    task automatic start();
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (status !== 3'd0) begin bad++; $display("FAIL reset_status got=%0d exp=0", status); end
        total++; if (value !== 32'd0) begin bad++; $display("FAIL reset_value got=%0d exp=0", value); end
        total++; if (src !== 1'b0) begin bad++; $display("FAIL reset_src got=%0d exp=0", src); end
        total++; if (cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        total++; if (passed !== 1'b0 || failed !== 1'b0) begin bad++; $display("FAIL reset_verdict got=%0b%0b exp=00", passed, failed); end
    endtask

    task automatic test_pass();
        do_reset();
        start();
        repeat (100) tick();
        total++; if (cnt !== 32'd100) begin bad++; $display("FAIL pass_live_cnt got=%0d exp=100", cnt); end
        pass = 2'b01;
        tick();
        pass = '0;
        total++; if (status !== 3'd1) begin bad++; $display("FAIL pass_status got=%0d exp=1", status); end
        total++; if (src !== 1'b0) begin bad++; $display("FAIL pass_src got=%0d exp=0", src); end
        total++; if (cnt !== 32'd100) begin bad++; $display("FAIL pass_cnt got=%0d exp=100", cnt); end
        total++; if (value !== 32'd0) begin bad++; $display("FAIL pass_value got=%0d exp=0", value); end
        repeat (15) tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL pass_done_early got=%0b exp=0", done); end
        total++; if (cnt !== 32'd100) begin bad++; $display("FAIL pass_cnt_frozen got=%0d exp=100", cnt); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL pass_done got=%0b exp=1", done); end
        total++; if (passed !== 1'b1 || failed !== 1'b0) begin bad++; $display("FAIL pass_verdict got=%0b%0b exp=10", passed, failed); end
        repeat (5) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL pass_done_sticky got=%0b exp=1", done); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        start();
        repeat (7) tick();
        pass = 2'b01;
        exit_valid = 2'b10;
        exit_value = {32'd5, 32'd0};
        tick();
        pass = '0;
        exit_valid = '0;
        exit_value = '0;
        total++; if (status !== 3'd4) begin bad++; $display("FAIL same_status got=%0d exp=4", status); end
        total++; if (src !== 1'b1) begin bad++; $display("FAIL same_src got=%0d exp=1", src); end
        total++; if (value !== 32'd5) begin bad++; $display("FAIL same_value got=%0d exp=5", value); end
        total++; if (cnt !== 32'd7) begin bad++; $display("FAIL same_cnt got=%0d exp=7", cnt); end
        repeat (16) tick();
        total++; if (done !== 1'b1 || failed !== 1'b1 || passed !== 1'b0) begin
            bad++; $display("FAIL same_verdict got done=%0b p=%0b f=%0b exp done=1 p=0 f=1", done, passed, failed);
        end
    endtask

    task automatic test_arbitration();
        // {pass, fail, exit_valid, v1, v0} -> {status, src, value}
        logic [1:0]  vp[7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
        logic [1:0]  vf[7] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0]  ve[7] = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b01};
        logic [31:0] v0[7] = '{32'd9, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] v1[7] = '{32'd0, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd8};
        logic [2:0]  es[7] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd1, 3'd3, 3'd3};
        logic        ec[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ev[7] = '{32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            do_reset();
            start();
            tick();
            pass = vp[i];
            fail = vf[i];
            exit_valid = ve[i];
            exit_value = {v1[i], v0[i]};
            tick();
            pass = '0;
            fail = '0;
            exit_valid = '0;
            exit_value = '0;
            total++; if (status !== es[i] || src !== ec[i] || value !== ev[i] || cnt !== 32'd1) begin
                bad++;
                $display("FAIL arb_%0d got st=%0d src=%0d val=%0d cnt=%0d exp st=%0d src=%0d val=%0d cnt=1",
                         i, status, src, value, cnt, es[i], ec[i], ev[i]);
            end
        end
    endtask

    task automatic test_fail_in_drain();
        do_reset();
        start();
        repeat (5) tick();
        pass = 2'b10;
        tick();
        pass = '0;
        repeat (3) tick();
        fail = 2'b11;
        exit_valid = 2'b01;
        exit_value = {32'd0, 32'd4};
        tick();
        fail = '0;
        exit_valid = '0;
        exit_value = '0;
        total++; if (status !== 3'd1 || src !== 1'b1 || value !== 32'd0) begin
            bad++; $display("FAIL drain_ignore got st=%0d src=%0d val=%0d exp st=1 src=1 val=0", status, src, value);
        end
        repeat (11) tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL drain_done_early got=%0b exp=0", done); end
        tick();
        total++; if (done !== 1'b1 || passed !== 1'b1 || status !== 3'd1) begin
            bad++; $display("FAIL drain_done got done=%0b p=%0b st=%0d exp done=1 p=1 st=1", done, passed, status);
        end
    endtask

    task automatic test_pause();
        do_reset();
        start();
        repeat (5) tick();
        enable = 1'b0;
        repeat (5) tick();
        total++; if (cnt !== 32'd5 || status !== 3'd0) begin
            bad++; $display("FAIL pause_hold got cnt=%0d st=%0d exp cnt=5 st=0", cnt, status);
        end
        enable = 1'b1;
        tick();
        total++; if (cnt !== 32'd6) begin bad++; $display("FAIL pause_resume got=%0d exp=6", cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        max_cycles = 32'd50;
        start();
        repeat (50) tick();
        total++; if (status !== 3'd0 || cnt !== 32'd50) begin
            bad++; $display("FAIL timeout_early got st=%0d cnt=%0d exp st=0 cnt=50", status, cnt);
        end
        tick();
        total++; if (status !== 3'd5 || cnt !== 32'd50 || src !== 1'b0 || value !== 32'd0) begin
            bad++; $display("FAIL timeout_fire got st=%0d cnt=%0d src=%0d val=%0d exp st=5 cnt=50 src=0 val=0", status, cnt, src, value);
        end
        tick();
        total++; if (cnt !== 32'd50) begin bad++; $display("FAIL timeout_frozen got=%0d exp=50", cnt); end
        do_reset();
        start();
        repeat (10000) tick();
        total++; if (status !== 3'd0 || cnt !== 32'd10000 || done !== 1'b0) begin
            bad++; $display("FAIL unlimited got st=%0d cnt=%0d done=%0b exp st=0 cnt=10000 done=0", status, cnt, done);
        end
    endtask

    task automatic test_wdog();
        do_reset();
        start();
        for (int i = 0; i < 5; i++) begin
            retire = 1'b1;
            tick();
            retire = 1'b0;
            repeat (18) tick();
        end
        total++; if (w_status !== 3'd0) begin bad++; $display("FAIL wdog_kept_alive got=%0d exp=0", w_status); end
        retire = 1'b1;
        tick();
        retire = 1'b0;
        repeat (20) tick();
        total++; if (w_status !== 3'd0) begin bad++; $display("FAIL wdog_early got=%0d exp=0", w_status); end
        tick();
        total++; if (w_status !== 3'd6 || w_src !== 1'b0 || w_cnt !== 32'd116) begin
            bad++; $display("FAIL wdog_fire got st=%0d src=%0d cnt=%0d exp st=6 src=0 cnt=116", w_status, w_src, w_cnt);
        end
        total++; if (w_done !== 1'b1 || w_failed !== 1'b1 || w_passed !== 1'b0) begin
            bad++; $display("FAIL wdog_done got done=%0b p=%0b f=%0b exp done=1 p=0 f=1", w_done, w_passed, w_failed);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        start();
        repeat (3) tick();
        pass = 2'b01;
        exit_valid = 2'b10;
        exit_value = {32'd0, 32'd0};
        tick();
        pass = '0;
        exit_valid = '0;
        repeat (5) tick();
        total++; if (status !== 3'd1) begin bad++; $display("FAIL mid_pre_status got=%0d exp=1", status); end
        rst_n = 1'b0;
        #1;
        total++; if (status !== 3'd0 || cnt !== 32'd0 || done !== 1'b0 || value !== 32'd0 || src !== 1'b0) begin
            bad++; $display("FAIL mid_async got st=%0d cnt=%0d done=%0b val=%0d src=%0d exp all 0", status, cnt, done, value, src);
        end
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        total++; if (status !== 3'd0 || cnt !== 32'd0 || done !== 1'b0) begin
            bad++; $display("FAIL mid_idle got st=%0d cnt=%0d done=%0b exp 0 0 0", status, cnt, done);
        end
        pass = 2'b01;
        tick();
        pass = '0;
        total++; if (status !== 3'd0) begin bad++; $display("FAIL idle_ignore got=%0d exp=0", status); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_same_cycle();
        test_arbitration();
        test_fail_in_drain();
        test_pause();
        test_timeout();
        test_wdog();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL time_limit reached got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/tb_exit_monitor.md
# tb_exit_monitor

Parametrised, synthesizable end-of-simulation monitor for the cv32e40p core testbench. It replaces ad-hoc pass/fail/exit checks and the plusarg cycle-abort logic in the top-level bench. It watches N exit channels plus a retirement-activity strobe, enforces a runtime cycle limit and an idle watchdog, and arbitrates simultaneous events deterministically. It latches one final status and exit value, then asserts a sticky `done_o` after a drain period so stdout peripherals can flush.

## Interface
- `NCH`, default 2: number of exit channels (≥1).
- `CNT_W`, default 32: width of the cycle counter and the cycle limit.
- `WDOG_CYCLES`, default 100000: idle cycles without `retire_i` before a watchdog event; 0 disables the watchdog.
- `DRAIN_CYCLES`, default 16: cycles between event capture and `done_o`; 0 allowed.
- Clocking and reset: one clock, `clk_i`; reset `rst_ni` is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  async active-low reset.
- `enable_i`  in  1  run enable (fetch enable); level.
- `max_cycles_i`  in  CNT_W  cycle limit; 0 = unlimited; sampled every cycle.
- `retire_i`  in  1  instruction-retire / activity strobe.
- `pass_i`  in  NCH  per-channel pass pulse.
- `fail_i`  in  NCH  per-channel fail pulse.
- `exit_valid_i`  in  NCH  per-channel exit strobe.
- `exit_value_i`  in  32*NCH  per-channel exit value; channel k at bits [32k+31:32k].
- `done_o`  out  1  sticky end-of-sim flag.
- `status_o`  out  3  final status code.
- `exit_value_o`  out  32  latched exit value.
- `src_ch_o`  out  max(1,$clog2(NCH))  channel that produced the event.
- `cycle_cnt_o`  out  CNT_W  cycle count, frozen at capture.
- `tests_passed_o`  out  1  `done_o` && status ∈ {PASS, EXIT_OK}.
- `tests_failed_o`  out  1  `done_o` && any other non-NONE status.

## Operation
- Status codes: NONE=0, PASS=1, FAIL=2, EXIT_OK=3, EXIT_ERR=4, TIMEOUT=5, WDOG=6.
- FSM states: IDLE → RUN → DRAIN → DONE.
  - IDLE→RUN when `enable_i`=1.
  - RUN→DRAIN on any event. If DRAIN_CYCLES=0, RUN→DONE directly.
  - DRAIN→DONE when the drain counter reaches DRAIN_CYCLES.
  - DONE is sticky until reset.
  - Deasserting `enable_i` in RUN pauses the counters but stays in RUN.
- Cycle counter: 0 in IDLE. Increments each RUN cycle with `enable_i`=1. Saturates at all-ones and never wraps.
- Event classes, in priority order (highest first):
  - FAIL: `fail_i[k]`.
  - EXIT_ERR: `exit_valid_i[k]` with value ≠ 0.
  - PASS: `pass_i[k]`.
  - EXIT_OK: `exit_valid_i[k]` with value = 0.
  - TIMEOUT: `max_cycles_i` ≠ 0 and cycle count ≥ `max_cycles_i`.
  - WDOG: idle count = WDOG_CYCLES, with WDOG_CYCLES ≠ 0.
- Within a class, the lowest channel index wins.
- Capture: in the winning cycle, latch `status_o`, `src_ch_o` (0 for TIMEOUT/WDOG), `exit_value_o` (the channel's value for exit classes, else 0) and `cycle_cnt_o`.
- Events are ignored in IDLE, DRAIN and DONE. The first capture is final.
- Idle counter: cleared when `retire_i`=1 or when not in RUN. Otherwise increments in RUN while `enable_i`=1, saturating at WDOG_CYCLES.
- Async reset mid-operation returns all state to IDLE and all outputs to reset values.

## Timing
- All outputs are registered.
- Reset values: `done_o`=0, `status_o`=0, `exit_value_o`=0, `src_ch_o`=0, `cycle_cnt_o`=0, `tests_passed_o`=0, `tests_failed_o`=0.
- While in RUN, `cycle_cnt_o` tracks the live counter.
- Event sampled at edge N → `status_o`, `exit_value_o` and `src_ch_o` valid after edge N; `cycle_cnt_o` frozen at the count from edge N.
- `done_o`, `tests_passed_o` and `tests_failed_o` rise after edge N+DRAIN_CYCLES.
- TIMEOUT with `max_cycles_i`=M fires at the edge where the counter already equals M, so the frozen count is M.
- WDOG fires WDOG_CYCLES cycles after the last `retire_i`.
- No handshake: inputs are single-cycle pulses sampled on the rising edge of `clk_i`.

## Structure
- `tb_exit_pkg` holds:
  - the `status_e` enum (3-bit) and `state_e` enum;
  - the `EXIT_VALUE_W`=32 constant;
  - a function mapping status to pass/fail.
- Sub-module `tb_exit_arbiter`: combinational priority encoder over NCH channels and the two internal events. Outputs event-valid, status, channel index and value.
- Counters and the FSM live in `tb_exit_monitor`.

## Test plan
- NCH=2, DRAIN=16: `pass_i`=2'b01 at cycle 100 → status 1, src 0, `cycle_cnt_o`=100, `done_o` and `tests_passed_o` high 16 cycles later.
- Same cycle: `pass_i[0]`, `exit_valid_i[1]` with value 5 → status 4 (EXIT_ERR), src 1, `exit_value_o`=5, `tests_failed_o`=1.
- `max_cycles_i`=50, no events → status 5, `cycle_cnt_o`=50. Then `max_cycles_i`=0 with a fresh reset → no timeout after 10k cycles.
- WDOG_CYCLES=20: `retire_i` stops at cycle 30 → status 6 at cycle 50. Toggling `retire_i` every 19 cycles → no WDOG.
- `fail_i` pulse during DRAIN after a PASS → status stays 1, `done_o` still rises on schedule.
- `rst_ni` low mid-DRAIN → all outputs 0 immediately. After release with `enable_i` low → stays IDLE, counter at 0.
